// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 write-only target. It decodes 16-bit host frames
// ({write, addr[6:0], data[7:0]}, MSB first) into the control registers used by
// pwm_peripheral. All SPI pins are asynchronous and are synchronised into clk.
module spi_reg_writer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Synchroniser chains; the last stage is the clk-domain view of each pin.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  // Frame capture state.
  logic [15:0]   shift_q;
  logic [4:0]    bit_cnt;
  logic          armed;
  logic          commit_pend;
  logic          err_pend;
  logic [AW-1:0] commit_addr;
  logic [7:0]    commit_data;
  logic [7:0]    regs [NUM_REGS];

  logic addr_ok;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign addr_ok   = (32'(shift_q[14:8]) < NUM_REGS);

  // Input synchronisers plus one edge-detect flop; reset to the idle bus state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  // Frame decode: ncs edges take priority over a coincident sclk edge, and a
  // decoded frame is applied one clk later so the register and its strobe
  // change together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      armed       <= 1'b0;
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe   <= commit_pend;
      frame_err   <= err_pend;
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;
      if (commit_pend) regs[commit_addr] <= commit_data;

      if (ncs_fall) begin
        shift_q <= '0;
        bit_cnt <= '0;
        armed   <= 1'b1;
      end else if (ncs_rise && armed) begin
        armed <= 1'b0;
        if (bit_cnt == 5'd16) begin
          // Reads and out-of-range addresses are dropped without any pulse.
          if (shift_q[15] && addr_ok) begin
            commit_pend <= 1'b1;
            commit_addr <= shift_q[AW+7:8];
            commit_data <= shift_q[7:0];
          end
        end else begin
          err_pend <= 1'b1;
        end
      end else if (sclk_rise && !ncs_s && armed) begin
        shift_q <= {shift_q[14:0], copi_s};
        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: drives SPI frames into spi_reg_writer and compares the
// register file, strobes and error pulses against a frame-level model.
module tb_spi_reg_writer;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_REGS    = 5;
  localparam int HALF        = 4;   // sclk half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic wr_strobe, frame_err;

  always #5 clk = ~clk;

  spi_reg_writer #(.SYNC_STAGES(SYNC_STAGES), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] model [NUM_REGS];
  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int last_strobe_cyc = -1;
  int t_rise = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_begin();
    ncs = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    wait_clks(HALF);
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    wait_clks(HALF);
    ncs = 1'b1;
    t_rise = cyc;
    wait_clks(12);
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits);
    spi_begin();
    for (int i = nbits - 1; i >= 0; i--) spi_bit(word[i]);
    spi_end();
  endtask

  // Frame-level model: only a complete 16-bit write to an existing register
  // changes state; any other length is a framing error.
  task automatic model_frame(input logic [31:0] word, input int nbits,
                             output int exp_strobe, output int exp_err);
    exp_strobe = 0;
    exp_err    = 0;
    if (nbits != 16) exp_err = 1;
    else if (word[15] && int'(word[14:8]) < NUM_REGS) begin
      model[word[14:8]] = word[7:0];
      exp_strobe = 1;
    end
  endtask

  task automatic check_regs(input string tag);
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back({24'h0, model[i]});
    chk({tag, ".r0"}, {24'h0, r0}, exp_q.pop_front());
    chk({tag, ".r1"}, {24'h0, r1}, exp_q.pop_front());
    chk({tag, ".r2"}, {24'h0, r2}, exp_q.pop_front());
    chk({tag, ".r3"}, {24'h0, r3}, exp_q.pop_front());
    chk({tag, ".r4"}, {24'h0, r4}, exp_q.pop_front());
  endtask

  task automatic run_frame(input string tag, input logic [31:0] word, input int nbits);
    int s0, e0, es, ee;
    s0 = strobe_cnt;
    e0 = err_cnt;
    model_frame(word, nbits, es, ee);
    send_frame(word, nbits);
    chk({tag, ".strobes"}, strobe_cnt - s0, es);
    chk({tag, ".errs"}, err_cnt - e0, ee);
    check_regs(tag);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    logic [31:0] w;
    int len;
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    wait_clks(3);
    chk("reset.strobe", {31'h0, wr_strobe}, 32'h0);
    chk("reset.err", {31'h0, frame_err}, 32'h0);
    check_regs("reset");
    rst = 1'b0;
    wait_clks(4);

    // Single write plus strobe latency.
    run_frame("wr_addr4", 32'h8455, 16);
    chk("wr_addr4.latency", last_strobe_cyc - t_rise, SYNC_STAGES + 2);

    // Back-to-back writes.
    run_frame("b2b_0", 32'h80F0, 16);
    run_frame("b2b_3", 32'h830F, 16);

    // Ignored frames.
    run_frame("bad_addr", 32'h8A12, 16);
    run_frame("read", 32'h0477, 16);

    // Framing errors.
    run_frame("short15", 32'h4155, 15);
    run_frame("long17", 32'h10455, 17);

    // Reset after bit 8 of a frame: outputs clear asynchronously.
    s0 = strobe_cnt;
    spi_begin();
    w = 32'h81AA;
    for (int i = 15; i >= 8; i--) spi_bit(w[i]);
    rst = 1'b1;
    #2;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    chk("midrst.strobe", {31'h0, wr_strobe}, 32'h0);
    chk("midrst.err", {31'h0, frame_err}, 32'h0);
    check_regs("midrst");
    wait_clks(2);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(w[i]);
    spi_end();
    chk("midrst_tail.strobes", strobe_cnt - s0, 0);
    check_regs("midrst_tail");
    run_frame("after_rst", 32'h81AA, 16);

    // Randomised frames.
    for (int k = 0; k < 24; k++) begin
      w = 32'($urandom_range(0, 3) != 0) << 15;
      w = w | (32'($urandom_range(0, 7)) << 8) | 32'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: len = 15;
        1: len = 17;
        default: len = 16;
      endcase
      if (len == 17) w = w | (32'($urandom_range(0, 1)) << 16);
      run_frame($sformatf("rnd%0d", k), w, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
